// File: rtl/ctrl_pkg.sv
// Shared encodings for the main control FSM and the downstream ALU-control decoder.
// The control word carries a trap bit only when CTRL_TRAP_EN is defined.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAddr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StRExec,
    StRWb,
    StAddiExec,
    StAddiWb,
    StBranch,
    StJump,
    StTrap
  } ctrl_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       retire;
`ifdef CTRL_TRAP_EN
    logic       trap;
`endif
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational state -> control word decode. Only ir_write/pc_write in FETCH and
// retire in MEM_WRITE look at mem_ready; reset forces the whole word to zero.
module ctrl_output_decode
  import ctrl_pkg::*;
(
  input  ctrl_state_e state,
  input  logic        mem_ready,
  input  logic        reset,
  output ctrl_word_t  ctrl
);

  always_comb begin
    ctrl = '0;
    if (!reset) begin
      unique case (state)
        StFetch: begin
          ctrl.mem_req   = 1'b1;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
          ctrl.alu_src_b = SRCB_ONE;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
        end
        StDecode: begin
          ctrl.alu_src_b = SRCB_BOFF;
          ctrl.alu_op    = ALUOP_ADD;
        end
        StMemAddr, StAddiExec: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        StMemRead: begin
          ctrl.mem_req = 1'b1;
          ctrl.i_or_d  = 1'b1;
        end
        StMemWb: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.retire     = 1'b1;
        end
        StMemWrite: begin
          ctrl.mem_req   = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
          ctrl.retire    = mem_ready;
        end
        StRExec: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_RT;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        StRWb: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
          ctrl.retire    = 1'b1;
        end
        StAddiWb: begin
          ctrl.reg_write = 1'b1;
          ctrl.retire    = 1'b1;
        end
        StBranch: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_RT;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
          ctrl.retire        = 1'b1;
        end
        StJump: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
          ctrl.retire    = 1'b1;
        end
`ifdef CTRL_TRAP_EN
        StTrap: ctrl.trap = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control: FETCH/DECODE/EXEC/MEM/WB sequencing plus retired-instruction counter.
// Define CTRL_TRAP_EN to trap on unknown opcodes (adds the trap port); otherwise they are NOPs.
module main_control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                retire,
`ifdef CTRL_TRAP_EN
  output logic                trap,
`endif
  output logic [CNT_W-1:0]    instr_count
);

  ctrl_state_e state;
  ctrl_word_t  ctrl;

  ctrl_output_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .reset     (reset),
    .ctrl      (ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StFetch;
      instr_count <= '0;
    end else begin
      if (ctrl.retire) instr_count <= instr_count + CNT_W'(1);
      unique case (state)
        StFetch:    if (mem_ready) state <= StDecode;
        StDecode: begin
          unique case (opcode)
            OPCODE_W'(OP_LW), OPCODE_W'(OP_SW): state <= StMemAddr;
            OPCODE_W'(OP_RTYPE):                state <= StRExec;
            OPCODE_W'(OP_BEQ):                  state <= StBranch;
            OPCODE_W'(OP_J):                    state <= StJump;
            OPCODE_W'(OP_ADDI):                 state <= StAddiExec;
`ifdef CTRL_TRAP_EN
            default:                            state <= StTrap;
`else
            default:                            state <= StFetch;
`endif
          endcase
        end
        StMemAddr:  state <= (opcode == OPCODE_W'(OP_LW)) ? StMemRead : StMemWrite;
        StMemRead:  if (mem_ready) state <= StMemWb;
        StMemWrite: if (mem_ready) state <= StFetch;
        StRExec:    state <= StRWb;
        StAddiExec: state <= StAddiWb;
        // Only reset leaves the trap state.
        StTrap:     state <= StTrap;
        default:    state <= StFetch;
      endcase
    end
  end

  assign mem_req       = ctrl.mem_req;
  assign mem_write     = ctrl.mem_write;
  assign i_or_d        = ctrl.i_or_d;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign retire        = ctrl.retire;
`ifdef CTRL_TRAP_EN
  assign trap          = ctrl.trap;
`endif

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: per-instruction step-sequence model checked every cycle,
// plus literal latency/count/write-back expectations. Counter width 4 to reach the wrap.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b1;
  logic [5:0] opcode = 6'b000000;

  logic       mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, retire;
  logic [3:0] instr_count;
  wire        trap_w;

  int vectors = 0;
  int miscompares = 0;

  main_control_fsm #(
    .OPCODE_W (6),
    .CNT_W    (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .retire        (retire),
`ifdef CTRL_TRAP_EN
    .trap          (trap_w),
`endif
    .instr_count   (instr_count)
  );

`ifndef CTRL_TRAP_EN
  assign trap_w = 1'b0;
`endif

  always #5 clk = ~clk;

  wire [17:0] act_word = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                          pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
                          mem_to_reg, retire, trap_w};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Steps after FETCH/DECODE, one letter per cycle, chosen by opcode.
  function automatic string tail(input logic [5:0] op);
    case (op)
      6'b100011: return "ARM";
      6'b101011: return "AS";
      6'b000000: return "XY";
      6'b000100: return "B";
      6'b000010: return "P";
      6'b001000: return "IJ";
`ifdef CTRL_TRAP_EN
      default:   return "T";
`else
      default:   return "";
`endif
    endcase
  endfunction

  function automatic logic [17:0] expect_word(input byte c, input logic mr, input logic rst);
    logic mreq, mw, iod, irw, pcw, pcc, sa, rw, rd, m2r, ret, tr;
    logic [1:0] ps, sb, ao;
    {mreq, mw, iod, irw, pcw, pcc, sa, rw, rd, m2r, ret, tr} = '0;
    ps = 2'b00; sb = 2'b00; ao = 2'b00;
    if (!rst) begin
      case (c)
        "F": begin mreq = 1; irw = mr; pcw = mr; sb = 2'b01; end
        "D": sb = 2'b11;
        "A", "I": begin sa = 1; sb = 2'b10; end
        "R": begin mreq = 1; iod = 1; end
        "M": begin rw = 1; m2r = 1; ret = 1; end
        "S": begin mreq = 1; mw = 1; iod = 1; ret = mr; end
        "X": begin sa = 1; ao = 2'b10; end
        "Y": begin rw = 1; rd = 1; ret = 1; end
        "J": begin rw = 1; ret = 1; end
        "B": begin sa = 1; ao = 2'b01; pcc = 1; ps = 2'b01; ret = 1; end
        "P": begin pcw = 1; ps = 2'b10; ret = 1; end
        "T": tr = 1;
        default: ;
      endcase
    end
    return {mreq, mw, iod, irw, pcw, pcc, ps, sa, sb, ao, rw, rd, m2r, ret, tr};
  endfunction

  string      seq = "FD";
  int         k = 0;
  int         cnt = 0;
  byte        cur;
  logic [17:0] exp_w;

  always @(negedge clk) begin
    cur   = seq[k];
    exp_w = expect_word(cur, mem_ready, reset);
    check("ctrl_word", {14'd0, act_word}, {14'd0, exp_w});
    check("instr_count", {28'd0, instr_count}, cnt);
    if (reset) begin
      seq = "FD"; k = 0; cnt = 0;
    end else if (cur == "T") begin
      k = k;
    end else if ((cur == "F" || cur == "R" || cur == "S") && !mem_ready) begin
      k = k;
    end else begin
      if (exp_w[1]) cnt = (cnt + 1) % 16;
      if (cur == "D") seq = {"FD", tail(opcode)};
      if (k == seq.len() - 1) begin seq = "FD"; k = 0; end
      else k++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    #1;
    check("reset_outs", {14'd0, act_word}, 32'd0);
    step();
    reset = 1'b0;
  endtask

  // Runs one instruction from FETCH; pat gives mem_ready per cycle ('1' beyond its end).
  task automatic run_instr(input string name, input logic [5:0] op, input string pat,
                           input int exp_cycles, input int exp_count, input logic [2:0] exp_wb);
    int cyc = 99;
    bit done = 0;
    opcode = op;
    for (int i = 0; i < 40 && !done; i++) begin
      mem_ready = (i < pat.len()) ? (pat[i] == "1") : 1'b1;
      #1;
      if (retire) begin
        done = 1;
        cyc = i + 1;
        check({name, "_wb"}, {29'd0, reg_write, reg_dst, mem_to_reg}, {29'd0, exp_wb});
      end
      step();
    end
    mem_ready = 1'b1;
    check({name, "_latency"}, cyc, exp_cycles);
    check({name, "_count"}, {28'd0, instr_count}, exp_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // 1: two reset cycles, then an R-type.
    #1;
    check("reset_c1", {14'd0, act_word}, 32'd0);
    step();
    check("reset_c2", {14'd0, act_word}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("first_fetch", {30'd0, mem_req, i_or_d}, 32'b10);
    run_instr("r_first", 6'b000000, "", 4, 1, 3'b110);

    // 2: LW with 3 wait cycles in FETCH and 2 in MEM_READ.
    reset_dut();
    run_instr("lw_wait", 6'b100011, "0001110011", 10, 1, 3'b101);

    // 3: SW, BEQ, J back to back.
    reset_dut();
    run_instr("sw", 6'b101011, "", 4, 1, 3'b000);
    run_instr("beq", 6'b000100, "", 3, 2, 3'b000);
    run_instr("j", 6'b000010, "", 3, 3, 3'b000);

    // 4: R-type then ADDI.
    reset_dut();
    run_instr("r", 6'b000000, "", 4, 1, 3'b110);
    run_instr("addi", 6'b001000, "", 4, 2, 3'b100);

    // 5: unknown opcode.
    reset_dut();
    opcode = 6'b111111;
    step();
    step();
    #1;
`ifdef CTRL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      check("trap_held", {30'd0, trap_w, mem_req}, 32'b10);
      step();
    end
    reset_dut();
    #1;
    check("trap_cleared", {30'd0, trap_w, mem_req}, 32'b01);
`else
    check("nop_to_fetch", {30'd0, mem_req, retire}, 32'b10);
`endif
    check("nop_count", {28'd0, instr_count}, 32'd0);

    // 6: reset during MEM_READ wait, then 16 retires to wrap the 4-bit counter.
    reset_dut();
    opcode = 6'b100011;
    mem_ready = 1'b1;
    step();
    step();
    step();
    mem_ready = 1'b0;
    #1;
    check("memread_wait", {30'd0, mem_req, i_or_d}, 32'b11);
    step();
    reset = 1'b1;
    #1;
    check("abort_outs", {14'd0, act_word}, 32'd0);
    step();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("abort_fetch", {30'd0, mem_req, i_or_d}, 32'b10);
    check("abort_count", {28'd0, instr_count}, 32'd0);
    for (int i = 0; i < 16; i++) run_instr("j_wrap", 6'b000010, "", 3, (i + 1) % 16, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
